// File: rtl/sa_pkg.sv
// Shared systolic-array definitions: default sizes, the ifmap feeder FSM
// encoding and the lane-slice convention (lane 0 sits in the most significant
// slice of a packed vector).
package sa_pkg;

    localparam int DEF_PE_SIZE    = 2;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_PSUM_WIDTH = 32;
    localparam int DEF_LEN_WIDTH  = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_LOAD  = ST_LOAD,
        S_DRAIN = ST_DRAIN
    } feeder_state_t;

    // LSB position of lane j inside a packed vector of pe_size lanes.
    function automatic int lane_lsb(int lane, int pe_size, int data_width);
        return data_width * (pe_size - lane - 1);
    endfunction

endpackage

// File: rtl/sa_skew_delay_line.sv
// Fixed-depth delay line carrying one lane's data and enable. Data entering
// with enable low is stored as zero, so a bubble always reads as 0/0.
// hold freezes every stage.
module sa_skew_delay_line #(
    parameter int DEPTH      = 1,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hold,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_en,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_en
);

    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]      en_q;

    // Shift data and enable one stage per cycle unless held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
            en_q <= '0;
        end else if (!hold) begin
            data_q[0] <= in_en ? in_data : '0;
            en_q[0]   <= in_en;
            for (int i = 1; i < DEPTH; i++) begin
                data_q[i] <= data_q[i-1];
                en_q[i]   <= en_q[i-1];
            end
        end
    end

    assign out_data = data_q[DEPTH-1];
    assign out_en   = en_q[DEPTH-1];

endmodule

// File: rtl/sa_ifmap_skew_feeder.sv
// Ifmap skew feeder: accepts one full vector per handshake, delays lane j by
// j+1 cycles so the array sees a diagonal wavefront, frames a tile of len
// vectors and drains the skew before pulsing done_o.
// Optional macro SA_FEEDER_STALL_EN adds stall_i, which freezes the whole
// block and masks enables, load_start and done while asserted.
//
// Handshake: a vector transfers in any cycle where in_valid_i and in_ready_o
// are both high; in_ready_o depends only on FSM state (and stall), never on
// in_valid_i, and in_data_i is only looked at in a transfer cycle.
module sa_ifmap_skew_feeder
    import sa_pkg::*;
#(
    parameter int PE_SIZE    = DEF_PE_SIZE,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
`ifdef SA_FEEDER_STALL_EN
    input  logic                          stall_i,
`endif
    input  logic                          start_i,
    input  logic [LEN_WIDTH-1:0]          len_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [DATA_WIDTH*PE_SIZE-1:0] in_data_i,
    output logic [DATA_WIDTH*PE_SIZE-1:0] ifmap_row_o,
    output logic [PE_SIZE-1:0]            ifmap_en_row_o,
    output logic                          ifmap_load_start_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic [1:0]                    dbg_state_o
);

    localparam int DRAIN_W = $clog2(PE_SIZE + 1);

    feeder_state_t        state_q;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] vec_cnt_q;
    logic [DRAIN_W-1:0]   drain_cnt_q;
    logic                 load_start_q;
    logic                 done_q;
    logic                 stall;
    logic                 hs;

`ifdef SA_FEEDER_STALL_EN
    assign stall = stall_i;
`else
    assign stall = 1'b0;
`endif

    assign in_ready_o         = (state_q == S_LOAD) && !stall;
    assign hs                 = in_valid_i && in_ready_o;
    assign busy_o             = (state_q != S_IDLE);
    assign ifmap_load_start_o = load_start_q && !stall;
    assign done_o             = done_q && !stall;
    assign dbg_state_o        = state_q;

    // Tile framing FSM; done is scheduled one cycle early so it lands with
    // the last lane's final element.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            vec_cnt_q    <= '0;
            drain_cnt_q  <= '0;
            load_start_q <= 1'b0;
            done_q       <= 1'b0;
        end else if (!stall) begin
            load_start_q <= 1'b0;
            done_q       <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        if (len_i != '0) begin
                            state_q   <= S_LOAD;
                            len_q     <= len_i;
                            vec_cnt_q <= '0;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (hs) begin
                        load_start_q <= (vec_cnt_q == '0);
                        // Compare against len-1 so len = 2^LEN_WIDTH-1 never wraps.
                        if (vec_cnt_q == len_q - LEN_WIDTH'(1)) begin
                            state_q     <= S_DRAIN;
                            vec_cnt_q   <= '0;
                            drain_cnt_q <= DRAIN_W'(1);
                            done_q      <= (PE_SIZE == 1);
                        end else begin
                            vec_cnt_q <= vec_cnt_q + LEN_WIDTH'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt_q == DRAIN_W'(PE_SIZE)) begin
                        state_q     <= S_IDLE;
                        drain_cnt_q <= '0;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + DRAIN_W'(1);
                        done_q      <= (drain_cnt_q == DRAIN_W'(PE_SIZE - 1));
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // One delay line per lane, depth j+1; non-handshake cycles inject bubbles.
    for (genvar j = 0; j < PE_SIZE; j++) begin : g_lane
        localparam int LSB = lane_lsb(j, PE_SIZE, DATA_WIDTH);
        logic lane_en;

        sa_skew_delay_line #(
            .DEPTH      (j + 1),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_delay (
            .clk      (clk),
            .rst      (rst),
            .hold     (stall),
            .in_data  (in_data_i[LSB +: DATA_WIDTH]),
            .in_en    (hs),
            .out_data (ifmap_row_o[LSB +: DATA_WIDTH]),
            .out_en   (lane_en)
        );

        assign ifmap_en_row_o[PE_SIZE-1-j] = lane_en && !stall;
    end

endmodule

// File: tb/tb_sa_ifmap_skew_feeder.sv
// Directed bench for sa_ifmap_skew_feeder with PE_SIZE=2, DATA_WIDTH=8.
// Observed word per cycle: {ifmap_row, en_row, load_start, done, busy, ready}.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_sa_ifmap_skew_feeder;

    localparam int PE = 2;
    localparam int DW = 8;
    localparam int LW = 8;
    localparam int OW = DW*PE + PE + 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stall_s = 1'b0;
    logic          start_i = 1'b0;
    logic [LW-1:0] len_i = '0;
    logic          in_valid_i = 1'b0;
    logic          in_ready_o;
    logic [15:0]   in_data_i = '0;
    logic [15:0]   ifmap_row_o;
    logic [1:0]    ifmap_en_row_o;
    logic          ifmap_load_start_o;
    logic          busy_o;
    logic          done_o;
    logic [1:0]    dbg_state_o;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q0 [$];
    logic [7:0] exp_q1 [$];

    sa_ifmap_skew_feeder #(.PE_SIZE(PE), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk                (clk),
        .rst                (rst),
`ifdef SA_FEEDER_STALL_EN
        .stall_i            (stall_s),
`endif
        .start_i            (start_i),
        .len_i              (len_i),
        .in_valid_i         (in_valid_i),
        .in_ready_o         (in_ready_o),
        .in_data_i          (in_data_i),
        .ifmap_row_o        (ifmap_row_o),
        .ifmap_en_row_o     (ifmap_en_row_o),
        .ifmap_load_start_o (ifmap_load_start_o),
        .busy_o             (busy_o),
        .done_o             (done_o),
        .dbg_state_o        (dbg_state_o)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, time %0t", $time);
        $fatal(1);
    end

    function automatic logic [OW-1:0] ew(logic [15:0] row, logic [1:0] en,
                                         logic ls, logic dn, logic bz, logic rd);
        return {row, en, ls, dn, bz, rd};
    endfunction

    function automatic logic [OW-1:0] obs();
        return {ifmap_row_o, ifmap_en_row_o, ifmap_load_start_o, done_o, busy_o, in_ready_o};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start_i = 1'b0; len_i = '0; in_valid_i = 1'b0; in_data_i = '0; stall_s = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs() !== '0 || dbg_state_o !== 2'd0) begin
            errors++;
            $display("FAIL reset_hold: got %h state %0d expected 0 state 0", obs(), dbg_state_o);
        end
        rst = 1'b0;
        step();
        checks++;
        if (obs() !== '0) begin
            errors++;
            $display("FAIL reset_release: got %h expected 0", obs());
        end
    endtask

    // len=3, valid held high: lane0 at t+1, lane1 at t+2, done with last lane1.
    task automatic test_basic();
        logic st[8]; logic [7:0] ln[8]; logic vl[8]; logic [15:0] dt[8]; logic [OW-1:0] ex[8];
        for (int i = 0; i < 8; i++) begin st[i]=0; ln[i]=0; vl[i]=0; dt[i]=0; ex[i]='0; end
        st[0]=1; ln[0]=8'd3;
        vl[1]=1; dt[1]=16'hA0A1;
        vl[2]=1; dt[2]=16'hB0B1;
        vl[3]=1; dt[3]=16'hC0C1;
        ex[1]=ew(16'h0000, 2'b00, 0, 0, 1, 1);
        ex[2]=ew(16'hA000, 2'b10, 1, 0, 1, 1);
        ex[3]=ew(16'hB0A1, 2'b11, 0, 0, 1, 1);
        ex[4]=ew(16'hC0B1, 2'b11, 0, 0, 1, 0);
        ex[5]=ew(16'h00C1, 2'b01, 0, 1, 1, 0);
        for (int c = 0; c < 7; c++) begin
            start_i=st[c]; len_i=ln[c]; in_valid_i=vl[c]; in_data_i=dt[c];
            checks++;
            if (obs() !== ex[c]) begin
                errors++;
                $display("FAIL basic cycle %0d: got %h expected %h", c, obs(), ex[c]);
            end
            step();
        end
        idle_inputs();
    endtask

    // Valid low for one LOAD cycle: bubble on each lane, done one cycle later.
    task automatic test_bubble();
        logic st[8]; logic [7:0] ln[8]; logic vl[8]; logic [15:0] dt[8]; logic [OW-1:0] ex[8];
        for (int i = 0; i < 8; i++) begin st[i]=0; ln[i]=0; vl[i]=0; dt[i]=0; ex[i]='0; end
        st[0]=1; ln[0]=8'd3;
        vl[1]=1; dt[1]=16'hA0A1;
        vl[2]=0; dt[2]=16'hFFFF;
        vl[3]=1; dt[3]=16'hB0B1;
        vl[4]=1; dt[4]=16'hC0C1;
        ex[1]=ew(16'h0000, 2'b00, 0, 0, 1, 1);
        ex[2]=ew(16'hA000, 2'b10, 1, 0, 1, 1);
        ex[3]=ew(16'h00A1, 2'b01, 0, 0, 1, 1);
        ex[4]=ew(16'hB000, 2'b10, 0, 0, 1, 1);
        ex[5]=ew(16'hC0B1, 2'b11, 0, 0, 1, 0);
        ex[6]=ew(16'h00C1, 2'b01, 0, 1, 1, 0);
        for (int c = 0; c < 8; c++) begin
            start_i=st[c]; len_i=ln[c]; in_valid_i=vl[c]; in_data_i=dt[c];
            checks++;
            if (obs() !== ex[c]) begin
                errors++;
                $display("FAIL bubble cycle %0d: got %h expected %h", c, obs(), ex[c]);
            end
            step();
        end
        idle_inputs();
    endtask

    // len=0: no LOAD, done pulses the next cycle, busy never rises.
    task automatic test_zero_len();
        logic [OW-1:0] ex[3];
        ex[0]='0; ex[1]=ew(16'h0000, 2'b00, 0, 1, 0, 0); ex[2]='0;
        for (int c = 0; c < 3; c++) begin
            start_i=(c == 0); len_i='0; in_valid_i=1'b1; in_data_i=16'h5566;
            checks++;
            if (obs() !== ex[c]) begin
                errors++;
                $display("FAIL zero_len cycle %0d: got %h expected %h", c, obs(), ex[c]);
            end
            step();
        end
        idle_inputs();
    endtask

    // start pulses in LOAD and DRAIN with other lengths must not disturb the tile.
    task automatic test_start_ignored();
        logic st[8]; logic [7:0] ln[8]; logic vl[8]; logic [15:0] dt[8]; logic [OW-1:0] ex[8];
        for (int i = 0; i < 8; i++) begin st[i]=0; ln[i]=0; vl[i]=0; dt[i]=0; ex[i]='0; end
        st[0]=1; ln[0]=8'd2;
        vl[1]=1; dt[1]=16'h4142; st[1]=1; ln[1]=8'd5;
        vl[2]=0; dt[2]=16'hFFFF; st[2]=1; ln[2]=8'd7;
        vl[3]=1; dt[3]=16'h5152;
        st[4]=1; ln[4]=8'd3;
        ex[1]=ew(16'h0000, 2'b00, 0, 0, 1, 1);
        ex[2]=ew(16'h4100, 2'b10, 1, 0, 1, 1);
        ex[3]=ew(16'h0042, 2'b01, 0, 0, 1, 1);
        ex[4]=ew(16'h5100, 2'b10, 0, 0, 1, 0);
        ex[5]=ew(16'h0052, 2'b01, 0, 1, 1, 0);
        for (int c = 0; c < 8; c++) begin
            start_i=st[c]; len_i=ln[c]; in_valid_i=vl[c]; in_data_i=dt[c];
            checks++;
            if (obs() !== ex[c]) begin
                errors++;
                $display("FAIL start_ignored cycle %0d: got %h expected %h", c, obs(), ex[c]);
            end
            step();
        end
        idle_inputs();
    endtask

    // Second tile started in the first IDLE cycle after done.
    task automatic test_back_to_back();
        logic st[10]; logic [7:0] ln[10]; logic vl[10]; logic [15:0] dt[10]; logic [OW-1:0] ex[10];
        for (int i = 0; i < 10; i++) begin st[i]=0; ln[i]=0; vl[i]=0; dt[i]=0; ex[i]='0; end
        st[0]=1; ln[0]=8'd2;
        vl[1]=1; dt[1]=16'h1112;
        vl[2]=1; dt[2]=16'h2122;
        st[5]=1; ln[5]=8'd1;
        vl[6]=1; dt[6]=16'h3132;
        ex[1]=ew(16'h0000, 2'b00, 0, 0, 1, 1);
        ex[2]=ew(16'h1100, 2'b10, 1, 0, 1, 1);
        ex[3]=ew(16'h2112, 2'b11, 0, 0, 1, 0);
        ex[4]=ew(16'h0022, 2'b01, 0, 1, 1, 0);
        ex[6]=ew(16'h0000, 2'b00, 0, 0, 1, 1);
        ex[7]=ew(16'h3100, 2'b10, 1, 0, 1, 0);
        ex[8]=ew(16'h0032, 2'b01, 0, 1, 1, 0);
        for (int c = 0; c < 10; c++) begin
            start_i=st[c]; len_i=ln[c]; in_valid_i=vl[c]; in_data_i=dt[c];
            checks++;
            if (obs() !== ex[c]) begin
                errors++;
                $display("FAIL back_to_back cycle %0d: got %h expected %h", c, obs(), ex[c]);
            end
            step();
        end
        idle_inputs();
    endtask

    // Asynchronous reset between edges during DRAIN, then a fresh tile.
    task automatic test_reset_mid_drain();
        logic [OW-1:0] ex[5];
        start_i=1'b1; len_i=8'd1; step();
        start_i=1'b0; len_i='0; in_valid_i=1'b1; in_data_i=16'h6162; step();
        in_valid_i=1'b0; in_data_i='0;
        checks++;
        if (obs() !== ew(16'h6100, 2'b10, 1, 0, 1, 0)) begin
            errors++;
            $display("FAIL rst_drain_pre: got %h expected %h", obs(), ew(16'h6100, 2'b10, 1, 0, 1, 0));
        end
        #3 rst = 1'b1;
        #1;
        checks++;
        if (obs() !== '0 || dbg_state_o !== 2'd0) begin
            errors++;
            $display("FAIL rst_drain_async: got %h state %0d expected 0 state 0", obs(), dbg_state_o);
        end
        #1 rst = 1'b0;
        step();
        ex[0]='0;
        ex[1]=ew(16'h0000, 2'b00, 0, 0, 1, 1);
        ex[2]=ew(16'h7100, 2'b10, 1, 0, 1, 0);
        ex[3]=ew(16'h0072, 2'b01, 0, 1, 1, 0);
        ex[4]='0;
        for (int c = 0; c < 5; c++) begin
            start_i=(c == 0); len_i=(c == 0) ? 8'd1 : 8'd0;
            in_valid_i=(c == 1); in_data_i=(c == 1) ? 16'h7172 : 16'h0000;
            checks++;
            if (obs() !== ex[c]) begin
                errors++;
                $display("FAIL rst_drain_fresh cycle %0d: got %h expected %h", c, obs(), ex[c]);
            end
            step();
        end
        idle_inputs();
    endtask

    // len = 2^LW-1 with a scoreboard per lane: no wrap, done at tL+2.
    task automatic test_max_len();
        int k = 0;
        int first_hs = -1, last_hs = -1, done_cyc = -1, ls_cnt = 0, ls_cyc = -1;
        logic [7:0] e;
        exp_q0.delete(); exp_q1.delete();
        start_i=1'b1; len_i=8'd255; step();
        start_i=1'b0; len_i='0;
        for (int c = 0; c < 400 && done_cyc < 0; c++) begin
            in_valid_i = 1'b1;
            in_data_i  = {8'(k + 1), 8'((k + 1) ^ 8'h5A)};
            if (ifmap_en_row_o[1]) begin
                e = (exp_q0.size() > 0) ? exp_q0.pop_front() : 8'hXX;
                checks++;
                if (ifmap_row_o[15:8] !== e) begin
                    errors++;
                    $display("FAIL max_len_lane0 cycle %0d: got %h expected %h", c, ifmap_row_o[15:8], e);
                end
            end
            if (ifmap_en_row_o[0]) begin
                e = (exp_q1.size() > 0) ? exp_q1.pop_front() : 8'hXX;
                checks++;
                if (ifmap_row_o[7:0] !== e) begin
                    errors++;
                    $display("FAIL max_len_lane1 cycle %0d: got %h expected %h", c, ifmap_row_o[7:0], e);
                end
            end
            if (ifmap_load_start_o) begin ls_cnt++; ls_cyc = c; end
            if (done_o) done_cyc = c;
            if (in_ready_o && in_valid_i) begin
                exp_q0.push_back(in_data_i[15:8]);
                exp_q1.push_back(in_data_i[7:0]);
                if (first_hs < 0) first_hs = c;
                last_hs = c;
                k++;
            end
            step();
        end
        idle_inputs();
        checks++;
        if (done_cyc < 0) begin
            errors++;
            $display("FAIL max_len_timeout: done not seen in 400 cycles, handshakes %0d", k);
        end
        checks++;
        if (k != 255) begin
            errors++;
            $display("FAIL max_len_count: got %0d handshakes expected 255", k);
        end
        checks++;
        if (done_cyc != last_hs + 2) begin
            errors++;
            $display("FAIL max_len_done: got cycle %0d expected %0d", done_cyc, last_hs + 2);
        end
        checks++;
        if (ls_cnt != 1 || ls_cyc != first_hs + 1) begin
            errors++;
            $display("FAIL max_len_load_start: got %0d pulses at %0d expected 1 at %0d", ls_cnt, ls_cyc, first_hs + 1);
        end
        checks++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            errors++;
            $display("FAIL max_len_drain: got %0d/%0d pending expected 0/0", exp_q0.size(), exp_q1.size());
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL max_len_busy: got %b expected 0", busy_o);
        end
    endtask

`ifdef SA_FEEDER_STALL_EN
    // Two stall cycles in LOAD: outputs masked, data held, done two cycles late.
    task automatic test_stall();
        logic st[9]; logic [7:0] ln[9]; logic vl[9]; logic sl[9]; logic [15:0] dt[9]; logic [OW-1:0] ex[9];
        for (int i = 0; i < 9; i++) begin st[i]=0; ln[i]=0; vl[i]=0; sl[i]=0; dt[i]=0; ex[i]='0; end
        st[0]=1; ln[0]=8'd3;
        vl[1]=1; dt[1]=16'hA0A1;
        vl[2]=1; dt[2]=16'hB0B1; sl[2]=1;
        vl[3]=1; dt[3]=16'hB0B1; sl[3]=1;
        vl[4]=1; dt[4]=16'hB0B1;
        vl[5]=1; dt[5]=16'hC0C1;
        ex[1]=ew(16'h0000, 2'b00, 0, 0, 1, 1);
        ex[2]=ew(16'hA000, 2'b00, 0, 0, 1, 0);
        ex[3]=ew(16'hA000, 2'b00, 0, 0, 1, 0);
        ex[4]=ew(16'hA000, 2'b10, 1, 0, 1, 1);
        ex[5]=ew(16'hB0A1, 2'b11, 0, 0, 1, 1);
        ex[6]=ew(16'hC0B1, 2'b11, 0, 0, 1, 0);
        ex[7]=ew(16'h00C1, 2'b01, 0, 1, 1, 0);
        for (int c = 0; c < 9; c++) begin
            start_i=st[c]; len_i=ln[c]; in_valid_i=vl[c]; in_data_i=dt[c]; stall_s=sl[c];
            checks++;
            if (obs() !== ex[c]) begin
                errors++;
                $display("FAIL stall cycle %0d: got %h expected %h", c, obs(), ex[c]);
            end
            step();
        end
        idle_inputs();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_bubble();
        test_zero_len();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_drain();
        test_max_len();
`ifdef SA_FEEDER_STALL_EN
        test_stall();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
